// File: rtl/rv_iopmp_axi_mem_responder.sv
// AXI4 subordinate word memory that terminates the IOPMP initiator port.
// Serves one burst at a time: strobed writes, burst reads, ID-matched B/R with DECERR/SLVERR.

package rv_iopmp_axi_mem_pkg;
  localparam int unsigned AXI_ADDR_WIDTH = 64;
  localparam int unsigned AXI_DATA_WIDTH = 64;
  localparam int unsigned AXI_ID_WIDTH   = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
  } axi_mem_ax_t;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0]   data;
    logic [AXI_DATA_WIDTH/8-1:0] strb;
    logic                        last;
  } axi_mem_w_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    logic [1:0]              resp;
  } axi_mem_b_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [1:0]                resp;
    logic                      last;
  } axi_mem_r_t;

  typedef struct packed {
    axi_mem_ax_t aw;
    logic        aw_valid;
    axi_mem_w_t  w;
    logic        w_valid;
    logic        b_ready;
    axi_mem_ax_t ar;
    logic        ar_valid;
    logic        r_ready;
  } axi_mem_req_t;

  typedef struct packed {
    logic       aw_ready;
    logic       ar_ready;
    logic       w_ready;
    axi_mem_b_t b;
    logic       b_valid;
    axi_mem_r_t r;
    logic       r_valid;
  } axi_mem_rsp_t;
endpackage

module rv_iopmp_axi_mem_responder #(
  parameter int unsigned           ADDR_WIDTH = rv_iopmp_axi_mem_pkg::AXI_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = rv_iopmp_axi_mem_pkg::AXI_DATA_WIDTH,
  parameter int unsigned           ID_WIDTH   = rv_iopmp_axi_mem_pkg::AXI_ID_WIDTH,
  parameter int unsigned           MEM_WORDS  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter type                   axi_req_t  = rv_iopmp_axi_mem_pkg::axi_mem_req_t,
  parameter type                   axi_rsp_t  = rv_iopmp_axi_mem_pkg::axi_mem_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  axi_req_t    axi_req_i,
  output axi_rsp_t    axi_rsp_o,
  output logic        busy_o,
  output logic [15:0] err_cnt_o
);
  import rv_iopmp_axi_mem_pkg::*;

  localparam int unsigned           STRB_W     = DATA_WIDTH / 8;
  localparam int unsigned           OFFS       = $clog2(STRB_W);
  localparam int unsigned           IDX_W      = $clog2(MEM_WORDS);
  localparam logic [2:0]            FULL_SIZE  = 3'(OFFS);
  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(STRB_W);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES  = ADDR_WIDTH'(MEM_WORDS * STRB_W);
  localparam logic [ADDR_WIDTH-1:0] LIMIT_ADDR = BASE_ADDR + MEM_BYTES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2,
    RDATA = 2'd3
  } state_e;

  // SLVERR dominates DECERR, which dominates OKAY.
  function automatic logic [1:0] merge_resp(input logic [1:0] a, input logic [1:0] b);
    if ((a == RESP_SLVERR) || (b == RESP_SLVERR)) begin
      return RESP_SLVERR;
    end else if ((a == RESP_DECERR) || (b == RESP_DECERR)) begin
      return RESP_DECERR;
    end else begin
      return RESP_OKAY;
    end
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e                  state_r, state_s;
  logic                    prio_wr_r;
  logic [ID_WIDTH-1:0]     id_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [7:0]              len_r;
  logic [7:0]              beat_cnt_r;
  logic [1:0]              burst_r;
  logic                    bad_burst_r;
  logic [1:0]              wresp_r;
  logic                    len_err_r;
  logic                    rd_err_r;
  logic                    b_valid_r;
  logic [ID_WIDTH-1:0]     b_id_r;
  logic [1:0]              b_resp_r;
  logic                    r_valid_r;
  logic [15:0]             err_cnt_r;
  logic [DATA_WIDTH-1:0]   mem_r [MEM_WORDS];

  logic                    idle_s, grant_w_s, grant_r_s;
  logic [ID_WIDTH-1:0]     ax_id_s;
  logic [ADDR_WIDTH-1:0]   ax_addr_s;
  logic [7:0]              ax_len_s;
  logic [2:0]              ax_size_s;
  logic [1:0]              ax_burst_s;
  logic                    ax_bad_s;
  logic                    in_range_s;
  logic [ADDR_WIDTH-1:0]   offset_s;
  logic [IDX_W-1:0]        idx_s;
  logic [1:0]              beat_resp_s;
  logic                    beat_ok_s;
  logic [ADDR_WIDTH-1:0]   next_addr_s;
  logic                    last_beat_s;
  logic                    w_hs_s, r_hs_s, b_hs_s;
  logic                    len_mismatch_s;
  logic [1:0]              bresp_final_s;
  logic [DATA_WIDTH-1:0]   r_data_s;

  assign idle_s    = (state_r == IDLE);
  assign grant_w_s = idle_s && axi_req_i.aw_valid && (!axi_req_i.ar_valid || prio_wr_r);
  assign grant_r_s = idle_s && axi_req_i.ar_valid && (!axi_req_i.aw_valid || !prio_wr_r);

  assign ax_id_s    = grant_w_s ? axi_req_i.aw.id    : axi_req_i.ar.id;
  assign ax_addr_s  = grant_w_s ? axi_req_i.aw.addr  : axi_req_i.ar.addr;
  assign ax_len_s   = grant_w_s ? axi_req_i.aw.len   : axi_req_i.ar.len;
  assign ax_size_s  = grant_w_s ? axi_req_i.aw.size  : axi_req_i.ar.size;
  assign ax_burst_s = grant_w_s ? axi_req_i.aw.burst : axi_req_i.ar.burst;
  // Reserved burst type 2'b11 is refused the same way as WRAP.
  assign ax_bad_s   = (ax_burst_s == BURST_WRAP) || (ax_burst_s == 2'b11) || (ax_size_s != FULL_SIZE);

  // Range check on the full byte address before the index is truncated.
  assign in_range_s  = (addr_r >= BASE_ADDR) && (addr_r < LIMIT_ADDR);
  assign offset_s    = addr_r - BASE_ADDR;
  assign idx_s       = IDX_W'(offset_s >> OFFS);
  assign beat_resp_s = bad_burst_r ? RESP_SLVERR : (in_range_s ? RESP_OKAY : RESP_DECERR);
  assign beat_ok_s   = (beat_resp_s == RESP_OKAY);
  assign next_addr_s = (burst_r == BURST_FIXED) ? addr_r : addr_r + WORD_BYTES;
  assign last_beat_s = (beat_cnt_r == len_r);

  assign w_hs_s = (state_r == WDATA) && axi_req_i.w_valid;
  assign r_hs_s = r_valid_r && axi_req_i.r_ready;
  assign b_hs_s = b_valid_r && axi_req_i.b_ready;

  assign len_mismatch_s = (axi_req_i.w.last != last_beat_s);
  assign bresp_final_s  = merge_resp(merge_resp(wresp_r, beat_resp_s),
                                     (len_err_r || len_mismatch_s) ? RESP_SLVERR : RESP_OKAY);

  assign r_data_s = (r_valid_r && beat_ok_s) ? mem_r[idx_s] : {DATA_WIDTH{1'b0}};

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_w_s) begin
          state_s = WDATA;
        end else if (grant_r_s) begin
          state_s = RDATA;
        end else begin
          state_s = IDLE;
        end
      end
      WDATA:   state_s = (w_hs_s && axi_req_i.w.last) ? WRESP : WDATA;
      WRESP:   state_s = b_hs_s ? IDLE : WRESP;
      RDATA:   state_s = (r_hs_s && last_beat_s) ? IDLE : RDATA;
      default: state_s = IDLE;
    endcase
  end

  // Burst control: address latch, beat tracking, response registers and error counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      prio_wr_r   <= 1'b1;
      id_r        <= {ID_WIDTH{1'b0}};
      addr_r      <= {ADDR_WIDTH{1'b0}};
      len_r       <= 8'd0;
      beat_cnt_r  <= 8'd0;
      burst_r     <= BURST_INCR;
      bad_burst_r <= 1'b0;
      wresp_r     <= RESP_OKAY;
      len_err_r   <= 1'b0;
      rd_err_r    <= 1'b0;
      b_valid_r   <= 1'b0;
      b_id_r      <= {ID_WIDTH{1'b0}};
      b_resp_r    <= RESP_OKAY;
      r_valid_r   <= 1'b0;
      err_cnt_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (grant_w_s || grant_r_s) begin
            id_r        <= ax_id_s;
            addr_r      <= ax_addr_s;
            len_r       <= ax_len_s;
            burst_r     <= ax_burst_s;
            bad_burst_r <= ax_bad_s;
            beat_cnt_r  <= 8'd0;
            wresp_r     <= RESP_OKAY;
            len_err_r   <= 1'b0;
            rd_err_r    <= 1'b0;
            prio_wr_r   <= grant_r_s;
            r_valid_r   <= grant_r_s;
          end
        end
        WDATA: begin
          if (w_hs_s) begin
            addr_r     <= next_addr_s;
            beat_cnt_r <= beat_cnt_r + 8'd1;
            wresp_r    <= merge_resp(wresp_r, beat_resp_s);
            len_err_r  <= len_err_r | len_mismatch_s;
            if (axi_req_i.w.last) begin
              b_valid_r <= 1'b1;
              b_id_r    <= id_r;
              b_resp_r  <= bresp_final_s;
              if (bresp_final_s != RESP_OKAY) begin
                err_cnt_r <= sat_inc(err_cnt_r);
              end
            end
          end
        end
        WRESP: begin
          if (b_hs_s) begin
            b_valid_r <= 1'b0;
          end
        end
        RDATA: begin
          if (r_hs_s) begin
            addr_r     <= next_addr_s;
            beat_cnt_r <= beat_cnt_r + 8'd1;
            rd_err_r   <= rd_err_r | !beat_ok_s;
            if (last_beat_s) begin
              r_valid_r <= 1'b0;
              if (rd_err_r || !beat_ok_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Strobe-masked memory write; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (w_hs_s && beat_ok_s) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (axi_req_i.w.strb[k]) begin
          mem_r[idx_s][8*k +: 8] <= axi_req_i.w.data[8*k +: 8];
        end
      end
    end
  end

  // Response assembly; R payload reads as zero whenever no beat is offered.
  always_comb begin
    axi_rsp_o.aw_ready = grant_w_s;
    axi_rsp_o.ar_ready = grant_r_s;
    axi_rsp_o.w_ready  = (state_r == WDATA);
    axi_rsp_o.b_valid  = b_valid_r;
    axi_rsp_o.b.id     = b_id_r;
    axi_rsp_o.b.resp   = b_resp_r;
    axi_rsp_o.r_valid  = r_valid_r;
    axi_rsp_o.r.id     = r_valid_r ? id_r : {ID_WIDTH{1'b0}};
    axi_rsp_o.r.data   = r_data_s;
    axi_rsp_o.r.resp   = r_valid_r ? beat_resp_s : RESP_OKAY;
    axi_rsp_o.r.last   = r_valid_r && last_beat_s;
  end

  assign busy_o    = (state_r != IDLE);
  assign err_cnt_o = err_cnt_r;

endmodule

// File: doc/rv_iopmp_axi_mem_responder.md
# rv_iopmp_axi_mem_responder

AXI4 subordinate with a small on-chip word memory. It serves as the far end of the IOPMP initiator port, where the IOPMP forwards checked DMA traffic toward the system interconnect. It accepts one burst at a time, performs strobe-masked writes and burst reads, and returns ID-matched B/R responses with DECERR/SLVERR for illegal accesses. Intended for integration benches and lint/FPGA bring-up of the IOPMP datapath.

## Interface
- ADDR_WIDTH, 64, AXI address width
- DATA_WIDTH, 64, AXI data width; power of two, ≥32
- ID_WIDTH, 4, AXI ID width (matches the IOPMP initiator side)
- MEM_WORDS, 256, memory depth in DATA_WIDTH words; power of two
- BASE_ADDR, 64'h8000_0000, byte address of word 0; aligned to MEM_WORDS*DATA_WIDTH/8
- axi_req_t, logic, AXI4 request struct (aw/w/ar channels, valids, b/r ready)
- axi_rsp_t, logic, AXI4 response struct (b/r channels, valids, aw/w/ar ready)
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset, asynchronous, active-high
- axi_req_i  in  axi_req_t  request from the IOPMP initiator port
- axi_rsp_o  out  axi_rsp_t  response to the IOPMP initiator port
- busy_o  out  1  high whenever FSM ≠ IDLE
- err_cnt_o  out  16  saturating count of bursts answered with a non-OKAY response

## Operation
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE: aw_ready and ar_ready are driven per arbitration. If only one channel is valid, that channel is granted. If both are valid, grant alternates; after reset, write wins first. Handshake latches id, addr, len, size, burst.
- Grant write → WDATA. w_ready = 1; each W handshake processes one beat. On the w_last handshake → WRESP.
- WRESP: b_valid = 1 with latched id and aggregate resp. Held stable until b_ready, then → IDLE.
- Grant read → RDATA. r_valid = 1 each beat with id, data, per-beat resp, and r_last on beat len. After the last handshake → IDLE.
- Beat address: word index = (addr − BASE_ADDR) >> log2(DATA_WIDTH/8), truncated to log2(MEM_WORDS) bits only after the range check.
  - INCR: index +1 per beat.
  - FIXED: index constant.
  - WRAP: whole burst answered SLVERR. Writes are discarded; read data is 0.
- Range check per beat: byte address < BASE_ADDR or ≥ BASE_ADDR + MEM_WORDS*DATA_WIDTH/8 → DECERR for that beat. The write beat is dropped; read data is 0.
- size ≠ log2(DATA_WIDTH/8) → SLVERR for the whole burst, same handling as WRAP.
- Write beats: byte lane k is written only when w_strb[k] = 1.
- Write response aggregation: SLVERR beats DECERR, which beats OKAY.
- Read data comes from a combinational memory read of the current index.
- err_cnt_o increments by 1 per burst whose B response, or any R beat, is non-OKAY. It saturates at 16'hFFFF.
- w_last mismatch: beats are counted. The burst ends on w_last; if w_last arrives early or late, B resp = SLVERR.
- Memory contents are not reset.

## Timing
- Reset values (asserted immediately, asynchronously):
  - all ready/valid outputs 0
  - b/r payload 0
  - busy_o 0, err_cnt_o 0
  - FSM IDLE, arbitration pointer = write
- Reset mid-burst abandons the transaction; no response is issued.
- AW/AR handshake at cycle N. w_ready or r_valid is first asserted at N+1. aw_ready/ar_ready are 0 outside IDLE.
- Write: one beat per cycle with w_valid high. b_valid is asserted the cycle after the w_last handshake.
- Read: first r_valid at N+1, one beat per cycle while r_ready = 1. Payload is held stable while r_valid && !r_ready.
- Throughput: back-to-back bursts need at least one IDLE cycle between the last handshake and the next address handshake.
- Valid is never dropped before its handshake completes.

## Test plan
- Write INCR len=3, addr 0x8000_0000, strb 0xFF, data 1..4 → B OKAY at w_last+1 with matching id. Read back len=3 → beats 1..4, r_last on the 4th, OKAY.
- Write strb 0x0F, data 0xAAAA_AAAA_BBBB_BBBB over a word holding 0x1111_1111_2222_2222 → readback 0x1111_1111_BBBB_BBBB.
- INCR burst len=1 starting at the last word (BASE + 0x7F8) → read beat 0 OKAY with data, beat 1 DECERR with data 0. err_cnt_o = 1.
- AW and AR valid in the same cycle, repeated twice after reset → write granted first, then read, then write. busy_o high during each burst.
- WRAP burst write → B SLVERR, memory unchanged. size=2 read → all beats SLVERR, data 0.
- Assert rst_i during RDATA beat 2 with r_ready=0 → r_valid=0 in the same cycle. After release, a fresh AR is accepted at its first valid cycle. err_cnt_o = 0.
